fetch_realign: RTL and testbench

- Sits directly upstream of the instruction queue, between the I$ response and its per-slot `instr_i`/`addr_i`/`valid_i` inputs.
- Splits each fetch packet into 16-bit parcels and classifies each parcel as compressed (bits[1:0] != 2'b11) or the lower half of a 32-bit instruction.
- Emits one aligned 32-bit instruction word plus its address per slot.
- Stitches 32-bit instructions that straddle two consecutive fetch packets by holding the lower parcel in a register.

---
 rtl/fetch_realign_pkg.sv | 19 +
 rtl/fetch_realign.sv | 118 +++++++++++
 tb/tb_fetch_realign.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fetch_realign_pkg.sv
// Shared fetch-side definitions: packet geometry, the parcel compression test,
// and the per-slot record handed to the instruction queue.
package fetch_realign_pkg;

    localparam int unsigned FETCH_WIDTH     = 32;
    localparam int unsigned INSTR_PER_FETCH = FETCH_WIDTH / 16;
    localparam int unsigned VLEN            = 39;

    typedef struct packed {
        logic [31:0]     instr;
        logic [VLEN-1:0] addr;
        logic            ex;
    } realign_slot_t;

    function automatic logic is_compressed(input logic [15:0] parcel);
        return parcel[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/fetch_realign.sv
// Re-aligns a fetch packet into per-parcel instruction slots, stitching a
// 32-bit instruction whose lower half ended the previous packet.
module fetch_realign #(
    parameter int unsigned FETCH_WIDTH = fetch_realign_pkg::FETCH_WIDTH,
    parameter int unsigned VLEN        = fetch_realign_pkg::VLEN
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                flush_i,
    input  logic                                valid_i,
    input  logic [VLEN-1:0]                     address_i,
    input  logic [FETCH_WIDTH-1:0]              data_i,
    input  logic                                exception_i,
    output logic [FETCH_WIDTH/16-1:0]           valid_o,
    output logic [(FETCH_WIDTH/16)*32-1:0]      instr_o,
    output logic [(FETCH_WIDTH/16)*VLEN-1:0]    addr_o,
    output logic [FETCH_WIDTH/16-1:0]           ex_o,
    output logic                                serving_unaligned_o
);
    import fetch_realign_pkg::*;

    localparam int P    = FETCH_WIDTH / 16;
    localparam int OFFW = $clog2(FETCH_WIDTH / 8);

    logic              unaligned_q, unaligned_d;
    logic [15:0]       unaligned_instr_q, unaligned_instr_d;
    logic [VLEN-1:0]   unaligned_addr_q, unaligned_addr_d;

    logic [OFFW-2:0]   off;
    logic [VLEN-1:0]   base;
    logic              stitch;
    logic              skip;
    logic [15:0]       parcel [P];

    assign off  = address_i[OFFW-1:1];
    assign base = {address_i[VLEN-1:OFFW], {OFFW{1'b0}}};

    // Only a packet that starts exactly where the held lower half left off may complete it.
    assign stitch = unaligned_q && valid_i && (off == '0)
                    && (base == unaligned_addr_q + VLEN'(2));

    assign serving_unaligned_o = unaligned_q;

    for (genvar g = 0; g < P; g++) begin : g_parcel
        assign parcel[g] = data_i[g*16 +: 16];
    end

    always_comb begin
        valid_o           = '0;
        ex_o              = '0;
        instr_o           = '0;
        addr_o            = '0;
        unaligned_d       = unaligned_q;
        unaligned_instr_d = unaligned_instr_q;
        unaligned_addr_d  = unaligned_addr_q;
        skip              = 1'b0;

        if (valid_i) begin
            unaligned_d = 1'b0;
            if (exception_i) begin
                if (stitch) begin
                    valid_o[0]         = 1'b1;
                    ex_o[0]            = 1'b1;
                    addr_o[VLEN-1:0]   = unaligned_addr_q;
                end else begin
                    valid_o[off]              = 1'b1;
                    ex_o[off]                 = 1'b1;
                    addr_o[off*VLEN +: VLEN]  = address_i;
                end
            end else begin
                if (stitch) begin
                    valid_o[0]       = 1'b1;
                    instr_o[31:0]    = {parcel[0], unaligned_instr_q};
                    addr_o[VLEN-1:0] = unaligned_addr_q;
                    skip             = 1'b1;
                end
                // skip marks a parcel already consumed as an upper half
                for (int p = 0; p < P; p++) begin
                    if (p < int'(off)) begin
                        skip = 1'b0;
                    end else if (skip) begin
                        skip = 1'b0;
                    end else if (is_compressed(parcel[p])) begin
                        valid_o[p]              = 1'b1;
                        instr_o[p*32 +: 32]     = {16'h0000, parcel[p]};
                        addr_o[p*VLEN +: VLEN]  = base + VLEN'(2 * p);
                    end else if (p + 1 < P) begin
                        valid_o[p]              = 1'b1;
                        instr_o[p*32 +: 32]     = {parcel[(p + 1) % P], parcel[p]};
                        addr_o[p*VLEN +: VLEN]  = base + VLEN'(2 * p);
                        skip                    = 1'b1;
                    end else begin
                        unaligned_d       = 1'b1;
                        unaligned_instr_d = parcel[p];
                        unaligned_addr_d  = base + VLEN'(2 * p);
                    end
                end
            end
        end

        if (flush_i) begin
            unaligned_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            unaligned_q       <= 1'b0;
            unaligned_instr_q <= '0;
            unaligned_addr_q  <= '0;
        end else begin
            unaligned_q       <= unaligned_d;
            unaligned_instr_q <= unaligned_instr_d;
            unaligned_addr_q  <= unaligned_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_realign.sv
// Table-driven bench for fetch_realign (FETCH_WIDTH=32): each row is driven for
// one cycle and its expected outputs are checked through a scoreboard queue.
module tb_fetch_realign;

    localparam int FW = 32;
    localparam int VL = 39;
    localparam int P  = FW / 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              flush_i;
    logic              valid_i;
    logic [VL-1:0]     address_i;
    logic [FW-1:0]     data_i;
    logic              exception_i;
    logic [P-1:0]      valid_o;
    logic [P*32-1:0]   instr_o;
    logic [P*VL-1:0]   addr_o;
    logic [P-1:0]      ex_o;
    logic              serving_unaligned_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          rst;
        logic          flush;
        logic          valid;
        logic          exc;
        logic [VL-1:0] addr;
        logic [31:0]   data;
        logic [1:0]    ev;
        logic [1:0]    eex;
        logic          es;
        logic [31:0]   ei0;
        logic [VL-1:0] ea0;
        logic [31:0]   ei1;
        logic [VL-1:0] ea1;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    fetch_realign #(.FETCH_WIDTH(FW), .VLEN(VL)) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .flush_i             (flush_i),
        .valid_i             (valid_i),
        .address_i           (address_i),
        .data_i              (data_i),
        .exception_i         (exception_i),
        .valid_o             (valid_o),
        .instr_o             (instr_o),
        .addr_o              (addr_o),
        .ex_o                (ex_o),
        .serving_unaligned_o (serving_unaligned_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic rst, input logic flush, input logic valid,
                                input logic exc, input logic [VL-1:0] addr,
                                input logic [31:0] data, input logic [1:0] ev,
                                input logic [1:0] eex, input logic es,
                                input logic [31:0] ei0, input logic [VL-1:0] ea0,
                                input logic [31:0] ei1, input logic [VL-1:0] ea1);
        vec_t v;
        v.rst = rst; v.flush = flush; v.valid = valid; v.exc = exc;
        v.addr = addr; v.data = data; v.ev = ev; v.eex = eex; v.es = es;
        v.ei0 = ei0; v.ea0 = ea0; v.ei1 = ei1; v.ea1 = ea1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk_i);
        #1;
        rst_i       = v.rst;
        flush_i     = v.flush;
        valid_i     = v.valid;
        exception_i = v.exc;
        address_i   = v.addr;
        data_i      = v.data;
        sb.push_back(v);
    endtask

    task automatic checkOutput(input int row);
        vec_t e;
        @(negedge clk_i);
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL row%0d scoreboard: got empty queue expected an entry", row);
            return;
        end
        e = sb.pop_front();
        check($sformatf("row%0d valid_o", row), 64'(valid_o), 64'(e.ev));
        check($sformatf("row%0d ex_o", row), 64'(ex_o), 64'(e.eex));
        check($sformatf("row%0d serving", row), 64'(serving_unaligned_o), 64'(e.es));
        if (e.ev[0]) begin
            check($sformatf("row%0d instr0", row), 64'(instr_o[31:0]), 64'(e.ei0));
            check($sformatf("row%0d addr0", row), 64'(addr_o[VL-1:0]), 64'(e.ea0));
        end
        if (e.ev[1]) begin
            check($sformatf("row%0d instr1", row), 64'(instr_o[63:32]), 64'(e.ei1));
            check($sformatf("row%0d addr1", row), 64'(addr_o[2*VL-1:VL]), 64'(e.ea1));
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; exception_i = 1'b0;
        address_i = '0; data_i = '0;

        //            rst  fl   vld  exc  addr           data           ev     eex    es   ei0           ea0            ei1           ea1
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h00A00513,  2'b01, 2'b00, 0, 32'h00A00513, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h45014505,  2'b11, 2'b00, 0, 32'h00004505, 39'h1000,      32'h00004501, 39'h1002));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1004,       32'h450100A0,  2'b11, 2'b00, 1, 32'h00A00513, 39'h1002,      32'h00004501, 39'h1006));
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1002,       32'h4501FFFF,  2'b10, 2'b00, 0, 32'h0,        39'h0,         32'h00004501, 39'h1002));
        // straddle, flush, then the matching packet must not stitch
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 1, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 1, 32'h0,        39'h0,         32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h1004,       32'h450100A0,  2'b11, 2'b00, 0, 32'h000000A0, 39'h1004,      32'h00004501, 39'h1006));
        // straddle followed by a discontinuous packet
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 0, 39'h2000,       32'h450100A0,  2'b11, 2'b00, 1, 32'h000000A0, 39'h2000,      32'h00004501, 39'h2002));
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        // straddle followed by a faulting packet
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 1, 1, 39'h1004,       32'h450100A0,  2'b01, 2'b01, 1, 32'h0,        39'h1002,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        // reset in the middle of a straddle
        tbl.push_back(mk(0, 0, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(1, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 1, 32'h0,        39'h0,         32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        // fault on an offset packet with nothing held
        tbl.push_back(mk(0, 0, 1, 1, 39'h1002,       32'h4501FFFF,  2'b10, 2'b10, 0, 32'h0,        39'h0,         32'h0,        39'h1002));
        // flush alongside a packet still shows its outputs but drops the lower half
        tbl.push_back(mk(0, 1, 1, 0, 39'h1000,       32'h05134505,  2'b01, 2'b00, 0, 32'h00004505, 39'h1000,      32'h0,        39'h0));
        tbl.push_back(mk(0, 0, 0, 0, 39'h0,          32'h0,         2'b00, 2'b00, 0, 32'h0,        39'h0,         32'h0,        39'h0));
        // top of the address space
        tbl.push_back(mk(0, 0, 1, 0, 39'h7FFFFFFFFE, 32'h4501FFFF,  2'b10, 2'b00, 0, 32'h0,        39'h0,         32'h00004501, 39'h7FFFFFFFFE));

        repeat (2) @(posedge clk_i);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
